// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions and the default base address.
package timer_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;

  localparam logic [3:0] TH_OFS    = 4'h0;
  localparam logic [3:0] TL_OFS    = 4'h4;
  localparam logic [3:0] TCON_OFS  = 4'h8;
  localparam logic [3:0] OVCNT_OFS = 4'hC;

  localparam int unsigned EN_BIT = 0;
  localparam int unsigned IE_BIT = 1;
  localparam int unsigned ST_BIT = 2;

  typedef enum logic [1:0] {
    SEL_TH    = 2'd0,
    SEL_TL    = 2'd1,
    SEL_TCON  = 2'd2,
    SEL_OVCNT = 2'd3
  } reg_sel_e;

  // Word select within the block; the byte lane bits are ignored.
  function automatic reg_sel_e ofs_to_sel(input logic [3:0] ofs);
    return reg_sel_e'(ofs[3:2]);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into count ticks: one tick every PRESCALE enabled cycles.
// Dropping the enable restarts the division from zero.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_last;

  assign w_last = (r_pcnt == LAST);
  assign o_tick = i_en & w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt <= '0;
    end else if (!i_en || w_last) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/timer_irq.sv
// Interval timer on the peripheral bus: counts up, reloads from TH on
// overflow, latches ST and raises irqout = IE & ST until software clears ST.
module timer_irq
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE     = DEFAULT_BASE,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned OVW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] rdata,
  output logic        irqout
);

  logic [31:0]    r_th;
  logic [31:0]    r_tl;
  logic           r_en;
  logic           r_ie;
  logic           r_st;
  logic [OVW-1:0] r_ovcnt;

  logic     w_hit;
  reg_sel_e w_sel;
  logic     w_wr_th, w_wr_tl, w_wr_tcon, w_wr_ov;
  logic     w_tick, w_ovf, w_ovf_set;

  assign w_hit     = (addr[31:4] == BASE[31:4]);
  assign w_sel     = ofs_to_sel(addr[3:0]);
  assign w_wr_th   = MemWr & w_hit & (w_sel == SEL_TH);
  assign w_wr_tl   = MemWr & w_hit & (w_sel == SEL_TL);
  assign w_wr_tcon = MemWr & w_hit & (w_sel == SEL_TCON);
  assign w_wr_ov   = MemWr & w_hit & (w_sel == SEL_OVCNT);

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_en   (r_en),
    .o_tick (w_tick)
  );

  // Overflow is judged on the pre-write TL, so a same-cycle TL store does not mask it.
  assign w_ovf     = w_tick & (r_tl == '1);
  assign w_ovf_set = w_ovf & r_ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th <= '0;
    end else if (w_wr_th) begin
      r_th <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tl <= '0;
    end else if (w_wr_tl) begin
      r_tl <= wdata;
    end else if (w_tick) begin
      r_tl <= w_ovf ? r_th : r_tl + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovcnt <= '0;
    end else if (w_wr_ov) begin
      r_ovcnt <= '0;
    end else if (w_ovf && (r_ovcnt != '1)) begin
      r_ovcnt <= r_ovcnt + OVW'(1);
    end
  end

  // ST can only be cleared by software; a same-cycle overflow wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_st <= 1'b0;
    end else if (w_wr_tcon) begin
      r_en <= wdata[EN_BIT];
      r_ie <= wdata[IE_BIT];
      r_st <= (wdata[ST_BIT] & r_st) | w_ovf_set;
    end else if (w_ovf_set) begin
      r_st <= 1'b1;
    end
  end

  assign irqout = r_ie & r_st;

  always_comb begin
    rdata = '0;
    if (MemRd && w_hit) begin
      case (w_sel)
        SEL_TH:    rdata = r_th;
        SEL_TL:    rdata = r_tl;
        SEL_TCON:  rdata = {29'd0, r_st, r_ie, r_en};
        SEL_OVCNT: rdata = 32'(r_ovcnt);
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: a PRESCALE=1 instance for register, overflow,
// interrupt and saturation behaviour, and a PRESCALE=4 instance for the prescaler.
module tb_timer_irq;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [3:0]  TH    = 4'h0;
  localparam logic [3:0]  TL    = 4'h4;
  localparam logic [3:0]  TCON  = 4'h8;
  localparam logic [3:0]  OVCNT = 4'hC;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRd;
  logic        wr1, wr4;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;

  int n_vec = 0;
  int n_err = 0;

  timer_irq #(.BASE(BASE), .PRESCALE(1), .OVW(8)) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemRd(MemRd), .MemWr(wr1), .rdata(rdata1), .irqout(irq1)
  );

  timer_irq #(.BASE(BASE), .PRESCALE(4), .OVW(8)) u_dut4 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemRd(MemRd), .MemWr(wr4), .rdata(rdata4), .irqout(irq4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input bit sel4, input logic [3:0] ofs, input logic [31:0] d);
    addr  = BASE + 32'(ofs);
    wdata = d;
    if (sel4) wr4 = 1'b1;
    else      wr1 = 1'b1;
    @(posedge clk);
    #1;
    wr1 = 1'b0;
    wr4 = 1'b0;
  endtask

  task automatic bus_rd(input bit sel4, input logic [31:0] a, output logic [31:0] d);
    addr  = a;
    MemRd = 1'b1;
    #1;
    d     = sel4 ? rdata4 : rdata1;
    MemRd = 1'b0;
  endtask

  task automatic chk_reg(input bit sel4, input logic [3:0] ofs, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    bus_rd(sel4, BASE + 32'(ofs), d);
    check32(tag, d, exp);
  endtask

  logic [31:0] rd_v;

  initial begin
    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    MemRd = 1'b0;
    wr1   = 1'b0;
    wr4   = 1'b0;
    #12 reset = 1'b0;
    step(1);

    chk_reg(0, TH,    32'h0, "rst_th");
    chk_reg(0, TL,    32'h0, "rst_tl");
    chk_reg(0, TCON,  32'h0, "rst_tcon");
    chk_reg(0, OVCNT, 32'h0, "rst_ovcnt");
    check32("rst_irq", 32'(irq1), 32'h0);

    // Bus decode
    bus_wr(0, TH, 32'hFFFF_FFFC);
    bus_rd(0, BASE + 32'h1, rd_v);
    check32("th_bytelane", rd_v, 32'hFFFF_FFFC);
    bus_rd(0, BASE + 32'h10, rd_v);
    check32("outside_blk", rd_v, 32'h0);
    addr = BASE; MemRd = 1'b0; #1;
    check32("no_rd_strobe", rdata1, 32'h0);

    // Read and write of TL in the same cycle returns the pre-edge value
    addr = BASE + 32'(TL); wdata = 32'hFFFF_FFFC; wr1 = 1'b1; MemRd = 1'b1; #1;
    check32("rdwr_pre_edge", rdata1, 32'h0);
    @(posedge clk); #1;
    wr1 = 1'b0; MemRd = 1'b0;

    // Overflow and interrupt
    bus_wr(0, TCON, 32'h3);
    chk_reg(0, TL, 32'hFFFF_FFFC, "tl_e0");
    step(1); chk_reg(0, TL, 32'hFFFF_FFFD, "tl_e1");
    step(1); chk_reg(0, TL, 32'hFFFF_FFFE, "tl_e2");
    step(1); chk_reg(0, TL, 32'hFFFF_FFFF, "tl_e3");
    check32("irq_e3", 32'(irq1), 32'h0);
    step(1);
    chk_reg(0, TL,    32'hFFFF_FFFC, "tl_reload");
    chk_reg(0, TCON,  32'h7,         "tcon_st_set");
    chk_reg(0, OVCNT, 32'h1,         "ovcnt_1");
    check32("irq_ovf", 32'(irq1), 32'h1);

    // ISR clear
    bus_wr(0, TCON, 32'h3);
    check32("irq_cleared", 32'(irq1), 32'h0);
    chk_reg(0, TCON, 32'h3,         "tcon_cleared");
    chk_reg(0, TL,   32'hFFFF_FFFD, "tl_continues");
    bus_wr(0, TCON, 32'h7);
    chk_reg(0, TCON, 32'h3, "st_no_sw_set");
    check32("irq_no_sw_set", 32'(irq1), 32'h0);
    step(2);
    chk_reg(0, OVCNT, 32'h2, "ovcnt_2");
    check32("irq_second_ovf", 32'(irq1), 32'h1);

    // Clear racing an overflow
    step(3);
    chk_reg(0, TL, 32'hFFFF_FFFF, "tl_pre_race");
    bus_wr(0, TCON, 32'h3);
    chk_reg(0, TCON,  32'h7,         "race_st_kept");
    chk_reg(0, TL,    32'hFFFF_FFFC, "race_tl_th");
    chk_reg(0, OVCNT, 32'h3,         "race_ovcnt");
    check32("race_irq", 32'(irq1), 32'h1);

    // IE=0: overflows counted, no status
    bus_wr(0, TCON, 32'h1);
    bus_wr(0, OVCNT, 32'hFFFF_FFFF);
    chk_reg(0, OVCNT, 32'h0, "ovcnt_wclr");
    step(10);
    chk_reg(0, OVCNT, 32'h3, "mask_ovcnt3");
    chk_reg(0, TCON,  32'h1, "mask_st0");
    check32("mask_irq", 32'(irq1), 32'h0);
    bus_wr(0, TCON, 32'h3);
    check32("ie_on_st0_irq", 32'(irq1), 32'h0);
    step(3);
    check32("ie_irq_up", 32'(irq1), 32'h1);
    bus_wr(0, TCON, 32'h5);
    check32("ie_off_irq", 32'(irq1), 32'h0);
    chk_reg(0, TCON, 32'h5, "ie_off_st_kept");

    // OVCNT saturation
    bus_wr(0, TCON, 32'h0);
    bus_wr(0, OVCNT, 32'h0);
    bus_wr(0, TH, 32'hFFFF_FFFF);
    bus_wr(0, TL, 32'hFFFF_FFFF);
    bus_wr(0, TCON, 32'h1);
    chk_reg(0, OVCNT, 32'h0, "sat_start");
    step(254); chk_reg(0, OVCNT, 32'd254, "sat_254");
    step(1);   chk_reg(0, OVCNT, 32'd255, "sat_255");
    step(45);  chk_reg(0, OVCNT, 32'd255, "sat_300");
    chk_reg(0, TL, 32'hFFFF_FFFF, "sat_tl");
    bus_wr(0, TCON, 32'h0);
    bus_wr(0, OVCNT, 32'h5A);
    chk_reg(0, OVCNT, 32'h0, "sat_wclr");

    // Asynchronous reset mid-cycle while irqout is high
    bus_wr(0, TCON, 32'h3);
    step(1);
    check32("pre_rst_irq", 32'(irq1), 32'h1);
    #3 reset = 1'b1;
    #1;
    check32("async_rst_irq", 32'(irq1), 32'h0);
    #1 reset = 1'b0;
    step(1);
    chk_reg(0, TH,    32'h0, "post_rst_th");
    chk_reg(0, TL,    32'h0, "post_rst_tl");
    chk_reg(0, TCON,  32'h0, "post_rst_tcon");
    chk_reg(0, OVCNT, 32'h0, "post_rst_ovcnt");

    // PRESCALE=4 instance
    bus_wr(1, TL, 32'h0);
    bus_wr(1, TCON, 32'h1);
    step(3); chk_reg(1, TL, 32'h0, "ps_3clk");
    step(1); chk_reg(1, TL, 32'h1, "ps_4clk");
    step(3); chk_reg(1, TL, 32'h1, "ps_7clk");
    step(1); chk_reg(1, TL, 32'h2, "ps_8clk");
    bus_wr(1, TCON, 32'h0);
    bus_wr(1, TL, 32'h0);
    bus_wr(1, TCON, 32'h1);
    step(5);
    bus_wr(1, TCON, 32'h0);
    step(4); chk_reg(1, TL, 32'h1, "ps_hold");
    bus_wr(1, TCON, 32'h1);
    step(3); chk_reg(1, TL, 32'h1, "ps_restart_3");
    step(1); chk_reg(1, TL, 32'h2, "ps_restart_4");
    check32("ps_irq", 32'(irq4), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
